// File: rtl/bec_la_pkg.sv
// Shared definitions for the BEC logic-analyzer operand link (read and write paths).
package bec_la_pkg;

    localparam int unsigned TAG_W   = 14;
    localparam int unsigned CHUNK_W = 82;

    localparam logic [15:0] MARKER_DATA = 16'hABC0;
    localparam logic [15:0] MARKER_DONE = 16'hABCF;
    localparam logic [15:0] CMD_ABORT   = 16'hAB00;

    localparam logic [TAG_W-1:0] TAG_CKSUM = 14'h3FFF;

    localparam int unsigned LA_ACK_BIT    = 96;
    localparam int unsigned LA_TOGGLE_BIT = 96;
    localparam int unsigned LA_VALID_BIT  = 97;
    localparam int unsigned LA_TAG_LSB    = 82;
    localparam int unsigned LA_CMD_LSB    = 112;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPresent,
        StAdvance,
        StDone
    } la_state_e;

    // Register k: hi chunk carries tag 2k+1, lo chunk 2k+2.
    function automatic logic [TAG_W-1:0] tag(input int unsigned k, input logic hi);
        return TAG_W'(2 * k + (hi ? 32'd1 : 32'd2));
    endfunction

endpackage

// File: rtl/bec_la_word_pack.sv
// Combinational chunk select and LA header assembly for one readout word.
module bec_la_word_pack
    import bec_la_pkg::*;
#(
    parameter int unsigned WIDTH = 163,
    parameter int unsigned NREGS = 7,
    parameter int unsigned IDX_W = 4
) (
    input  logic [NREGS*WIDTH-1:0] snap,
    input  logic [IDX_W-1:0]       idx,
    input  logic                   toggle,
    input  logic                   active,
    input  logic                   finished,
    input  logic                   ck_sel,
    input  logic [CHUNK_W-1:0]     cksum,
    output logic [127:0]           word
);

    logic [WIDTH-1:0]   reg_sel;
    logic [IDX_W-1:0]   reg_idx;
    logic               hi;
    logic [CHUNK_W-1:0] payload;
    logic [TAG_W-1:0]   tg;

    always_comb begin
        reg_idx = idx >> 1;
        hi      = ~idx[0];
        reg_sel = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (reg_idx == IDX_W'(r)) reg_sel = snap[r*WIDTH +: WIDTH];
        end
        payload = hi ? CHUNK_W'(reg_sel >> CHUNK_W) : reg_sel[CHUNK_W-1:0];
        tg      = tag(32'(reg_idx), hi);
        if (ck_sel) begin
            payload = cksum;
            tg      = TAG_CKSUM;
        end

        word = '0;
        if (active) begin
            word[LA_CMD_LSB +: 16]      = finished ? MARKER_DONE : MARKER_DATA;
            word[LA_VALID_BIT]          = ~finished;
            word[LA_TOGGLE_BIT]         = toggle;
            word[LA_TAG_LSB +: TAG_W]   = tg;
            word[CHUNK_W-1:0]           = payload;
        end
    end

endmodule

// File: rtl/bec_la_readout.sv
// LA readout: snapshots NREGS field registers and streams them as tagged 82-bit chunks.
// Define BEC_READOUT_CKSUM_EN to append an XOR checksum word after the last data word.
module bec_la_readout
    import bec_la_pkg::*;
#(
    parameter int unsigned WIDTH = 163,
    parameter int unsigned NREGS = 7
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   start_i,
    input  logic [NREGS*WIDTH-1:0] res_i,
    output logic                   busy_o,
    output logic                   done_o,
    input  logic [127:0]           la_data_in,
    input  logic [127:0]           la_oenb,
    output logic [127:0]           la_data_out
);

`ifdef BEC_READOUT_CKSUM_EN
    localparam int unsigned NWORDS = 2 * NREGS + 1;
`else
    localparam int unsigned NWORDS = 2 * NREGS;
`endif
    localparam int unsigned      IDX_W    = $clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    la_state_e              state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   tx_toggle_q;
    logic [NREGS*WIDTH-1:0] snap_q;
    logic                   ack;
    logic                   abort;
    logic                   ck_sel;
    logic [CHUNK_W-1:0]     cksum;
    logic                   unused_la;

    assign ack   = (la_data_in[LA_ACK_BIT] == tx_toggle_q) && !la_oenb[LA_ACK_BIT];
    assign abort = (la_data_in[LA_CMD_LSB +: 16] == CMD_ABORT)
                && (la_oenb[LA_CMD_LSB +: 16] == 16'h0000);
    assign unused_la = ^{la_data_in[111:97], la_data_in[95:0], la_oenb[111:97], la_oenb[95:0]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            tx_toggle_q <= 1'b0;
            snap_q      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state_q != StIdle && abort) begin
                state_q <= StIdle;
                busy_o  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            state_q <= StLoad;
                            busy_o  <= 1'b1;
                        end
                    end
                    StLoad: begin
                        snap_q      <= res_i;
                        idx_q       <= '0;
                        tx_toggle_q <= ~tx_toggle_q;
                        state_q     <= StPresent;
                    end
                    StPresent: begin
                        if (ack) state_q <= StAdvance;
                    end
                    StAdvance: begin
                        // Index stays on the last word so DONE keeps showing its tag/payload.
                        if (idx_q == LAST_IDX) begin
                            state_q <= StDone;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else begin
                            idx_q       <= idx_q + 1'b1;
                            tx_toggle_q <= ~tx_toggle_q;
                            state_q     <= StPresent;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef BEC_READOUT_CKSUM_EN
    logic [CHUNK_W-1:0] cksum_q;

    assign ck_sel = (idx_q == LAST_IDX);
    assign cksum  = cksum_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cksum_q <= '0;
        end else if (state_q == StLoad) begin
            cksum_q <= '0;
        end else if (state_q == StPresent && ack && !abort && !ck_sel) begin
            cksum_q <= cksum_q ^ la_data_out[CHUNK_W-1:0];
        end
    end
`else
    assign ck_sel = 1'b0;
    assign cksum  = '0;
`endif

    bec_la_word_pack #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_pack (
        .snap     (snap_q),
        .idx      (idx_q),
        .toggle   (tx_toggle_q),
        .active   (state_q inside {StPresent, StAdvance, StDone}),
        .finished (state_q == StDone),
        .ck_sel   (ck_sel),
        .cksum    (cksum),
        .word     (la_data_out)
    );

endmodule

// File: tb/tb_bec_la_readout.sv
// Directed self-checking bench for bec_la_readout (honours BEC_READOUT_CKSUM_EN).
module tb_bec_la_readout;

    localparam int W = 163;
    localparam int N = 7;
`ifdef BEC_READOUT_CKSUM_EN
    localparam int NW = 2 * N + 1;
`else
    localparam int NW = 2 * N;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [N*W-1:0] res;
    logic           busy;
    logic           done;
    logic [127:0]   din;
    logic [127:0]   oenb;
    logic [127:0]   dout;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic        exp_tog;
    logic [W-1:0] regv [N];
    logic [W-1:0] base;

    always #5 clk = ~clk;

    bec_la_readout #(
        .WIDTH (W),
        .NREGS (N)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .start_i     (start),
        .res_i       (res),
        .busy_o      (busy),
        .done_o      (done),
        .la_data_in  (din),
        .la_oenb     (oenb),
        .la_data_out (dout)
    );

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [81:0] exp_payload(input int w);
        logic [W-1:0] r;
        r = regv[w / 2];
        return (w % 2 == 0) ? 82'(r >> 82) : r[81:0];
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_res();
        for (int k = 0; k < N; k++) res[k*W +: W] = regv[k];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        oenb  = '1;
        load_res();
        step(2);
        rst_n = 1'b1;
        step(1);
        exp_tog = 1'b0;
    endtask

    // Leaves the bench at the negedge where the first word is visible.
    task automatic start_stream();
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        exp_tog = ~exp_tog;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (dout !== 128'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", dout); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        start_stream();
        n_cmp++; if (dout[97] !== 1'b1) begin n_fail++; $display("FAIL pre_async_valid: got %b want 1", dout[97]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (dout !== 128'h0) begin n_fail++; $display("FAIL async_out: got %h want 0", dout); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b want 0", busy); end
        step(1);
        rst_n = 1'b1;
        exp_tog = 1'b0;
        step(2);
        n_cmp++; if (dout !== 128'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got out=%h busy=%b want 0/0", dout, busy);
        end
        start_stream();
        n_cmp++; if (dout[95:82] !== 14'd1 || dout[96] !== 1'b1) begin
            n_fail++; $display("FAIL restart_after_reset: got tag=%h tog=%b want 1/1", dout[95:82], dout[96]);
        end
    endtask

    task automatic test_first_word();
        do_reset();
        start_stream();
        n_cmp++; if (dout[95:82] !== 14'd1) begin n_fail++; $display("FAIL w0_tag: got %h want 1", dout[95:82]); end
        n_cmp++; if (dout[81:0] !== exp_payload(0)) begin
            n_fail++; $display("FAIL w0_payload: got %h want %h", dout[81:0], exp_payload(0));
        end
        n_cmp++; if (dout[81] !== 1'b0) begin n_fail++; $display("FAIL w0_bit81: got %b want 0", dout[81]); end
        n_cmp++; if (dout[97] !== 1'b1 || dout[96] !== 1'b1) begin
            n_fail++; $display("FAIL w0_valid_tog: got %b%b want 11", dout[97], dout[96]);
        end
        n_cmp++; if (dout[127:112] !== 16'hABC0) begin n_fail++; $display("FAIL w0_marker: got %h want abc0", dout[127:112]); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL w0_busy: got %b want 1", busy); end
        din[96] = 1'b1;
        oenb[96] = 1'b0;
        step(1);
        n_cmp++; if (dout[95:82] !== 14'd1) begin n_fail++; $display("FAIL advance_hold: got %h want 1", dout[95:82]); end
        step(1);
        exp_tog = ~exp_tog;
        n_cmp++; if (dout[95:82] !== 14'd2 || dout[81:0] !== exp_payload(1) || dout[96] !== 1'b0) begin
            n_fail++; $display("FAIL w1: got tag=%h pl=%h tog=%b want 2/%h/0", dout[95:82], dout[81:0], dout[96], exp_payload(1));
        end
    endtask

    task automatic test_full_stream();
        logic [81:0] xsum;
        logic [81:0] ep;
        logic [13:0] et;
        int          c0;
        do_reset();
        oenb[96] = 1'b0;
        xsum = '0;
        et = '0;
        c0 = done_cnt;
        start_stream();
        for (int w = 0; w < NW; w++) begin
            ep = (w < 2 * N) ? exp_payload(w) : xsum;
            et = (w < 2 * N) ? 14'(w + 1) : 14'h3FFF;
            n_cmp++; if (dout[95:82] !== et || dout[81:0] !== ep) begin
                n_fail++; $display("FAIL stream_w%0d: got tag=%h pl=%h want %h/%h", w, dout[95:82], dout[81:0], et, ep);
            end
            n_cmp++; if (dout[97] !== 1'b1 || dout[96] !== exp_tog || busy !== 1'b1) begin
                n_fail++; $display("FAIL stream_hdr_w%0d: got v=%b t=%b b=%b want 1/%b/1", w, dout[97], dout[96], busy, exp_tog);
            end
            if (w < 2 * N) xsum = xsum ^ ep;
            din[96] = exp_tog;
            // A start during the stream must not re-snapshot the changed result bus.
            if (w == 3) begin
                start = 1'b1;
                res = ~res;
            end
            step(1);
            start = 1'b0;
            step(1);
            if (w < NW - 1) exp_tog = ~exp_tog;
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_pulse: got done=%b busy=%b want 1/0", done, busy);
        end
        n_cmp++; if (dout[127:112] !== 16'hABCF || dout[97] !== 1'b0 || dout[95:82] !== et) begin
            n_fail++; $display("FAIL done_word: got mk=%h v=%b tag=%h want abcf/0/%h", dout[127:112], dout[97], dout[95:82], et);
        end
        step(1);
        n_cmp++; if (done !== 1'b0 || dout !== 128'h0) begin
            n_fail++; $display("FAIL after_done: got done=%b out=%h want 0/0", done, dout);
        end
        step(1);
        n_cmp++; if (done_cnt - c0 !== 1) begin n_fail++; $display("FAIL done_count: got %0d want 1", done_cnt - c0); end
        load_res();
    endtask

    task automatic test_stale_ack();
        do_reset();
        oenb[96] = 1'b0;
        start_stream();
        din[96] = 1'b1;
        step(2);
        exp_tog = ~exp_tog;
        n_cmp++; if (dout[95:82] !== 14'd2) begin n_fail++; $display("FAIL stale_first: got %h want 2", dout[95:82]); end
        step(4);
        n_cmp++; if (dout[95:82] !== 14'd2 || dout[97] !== 1'b1) begin
            n_fail++; $display("FAIL stale_held: got tag=%h v=%b want 2/1", dout[95:82], dout[97]);
        end
        oenb[96] = 1'b1;
        din[96] = 1'b0;
        step(4);
        n_cmp++; if (dout[95:82] !== 14'd2) begin n_fail++; $display("FAIL oenb_ignored: got %h want 2", dout[95:82]); end
        oenb[96] = 1'b0;
        step(2);
        exp_tog = ~exp_tog;
        n_cmp++; if (dout[95:82] !== 14'd3 || dout[96] !== exp_tog) begin
            n_fail++; $display("FAIL ack_enabled: got tag=%h tog=%b want 3/%b", dout[95:82], dout[96], exp_tog);
        end
    endtask

    task automatic test_abort();
        int c0;
        do_reset();
        oenb[96] = 1'b0;
        start_stream();
        for (int w = 0; w < 4; w++) begin
            din[96] = exp_tog;
            step(2);
            exp_tog = ~exp_tog;
        end
        n_cmp++; if (dout[95:82] !== 14'd5) begin n_fail++; $display("FAIL abort_pre_tag: got %h want 5", dout[95:82]); end
        din[127:112] = 16'hAB00;
        oenb[127:112] = 16'h0001;
        step(1);
        n_cmp++; if (dout[97] !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_masked: got v=%b busy=%b want 1/1", dout[97], busy);
        end
        c0 = done_cnt;
        oenb[127:112] = 16'h0000;
        din[96] = exp_tog;
        step(1);
        n_cmp++; if (dout !== 128'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort: got out=%h busy=%b done=%b want 0/0/0", dout, busy, done);
        end
        din[127:112] = 16'h0000;
        oenb[127:112] = 16'hFFFF;
        step(3);
        n_cmp++; if (dout !== 128'h0 || done_cnt !== c0) begin
            n_fail++; $display("FAIL abort_quiet: got out=%h dones=%0d want 0/%0d", dout, done_cnt, c0);
        end
        start_stream();
        n_cmp++; if (dout[95:82] !== 14'd1 || dout[97] !== 1'b1 || dout[96] !== exp_tog || dout[81:0] !== exp_payload(0)) begin
            n_fail++; $display("FAIL abort_restart: got tag=%h v=%b t=%b pl=%h want 1/1/%b/%h",
                               dout[95:82], dout[97], dout[96], dout[81:0], exp_tog, exp_payload(0));
        end
    endtask

    initial begin
        base = {3'b001, 160'h2345_6789_ABCD_EF01_2345_6789_ABCD_EF01_2345_6789};
        for (int k = 0; k < N; k++) begin
            regv[k] = base ^ (163'(k) << 150) ^ (163'(3 * k + 1) << 60) ^ 163'(k * 7 + 5);
        end
        din  = '0;
        oenb = '1;
        load_res();
        test_reset();
        test_first_word();
        test_full_stream();
        test_stale_ack();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
